bcd_odo_counter_n: RTL and testbench

//  Parametrised N-digit BCD odometer: up/down count, synchronous clear and load, wrap or saturate mode.

---
 rtl/bcd_odo_counter_n.sv | 119 +++++++++++
 tb/tb_bcd_odo_counter_n.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_odo_counter_n.sv
// ============================================================================
//  Module      : bcd_odo_counter_n
//  Description : N-digit BCD odometer with up/down count, synchronous clear
//                and load, and wrap or saturate behaviour at the range limits.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module bcd_odo_counter_n #(
    parameter int DIGITS   = 3,
    parameter int SATURATE = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_bcd,
    input  logic                  inc,
    input  logic                  dec,
    output logic [4*DIGITS-1:0]   count_bcd,
    output logic                  ovf,
    output logic                  unf,
    output logic                  load_err,
    output logic                  is_zero,
    output logic                  is_max
);

    localparam int c_W   = 4 * DIGITS;
    localparam bit c_SAT = (SATURATE != 0);

    logic [c_W-1:0]    r_count;
    logic              r_ovf;
    logic              r_unf;
    logic              r_load_err;

    logic [DIGITS:0]   w_carry;
    logic [DIGITS:0]   w_borrow;
    logic [c_W-1:0]    w_inc_val;
    logic [c_W-1:0]    w_dec_val;
    logic [DIGITS-1:0] w_digit_ok;

    logic [c_W-1:0]    w_next;
    logic              w_ovf;
    logic              w_unf;
    logic              w_load_err;

    assign w_carry[0]  = 1'b1;
    assign w_borrow[0] = 1'b1;

    // Carry out of the top digit is set only when every digit is 9, and the
    // borrow out only when every digit is 0, so they double as the flag decodes.
    generate
        for (genvar k = 0; k < DIGITS; k++) begin : g_digit
            logic [3:0] w_d;
            assign w_d = r_count[4*k +: 4];

            assign w_inc_val[4*k +: 4] = !w_carry[k]    ? w_d   :
                                         (w_d == 4'd9)  ? 4'd0  : w_d + 4'd1;
            assign w_carry[k+1]        = w_carry[k] & (w_d == 4'd9);

            assign w_dec_val[4*k +: 4] = !w_borrow[k]   ? w_d   :
                                         (w_d == 4'd0)  ? 4'd9  : w_d - 4'd1;
            assign w_borrow[k+1]       = w_borrow[k] & (w_d == 4'd0);

            assign w_digit_ok[k]       = (load_bcd[4*k +: 4] <= 4'd9);
        end
    endgenerate

    always_comb begin
        w_next     = r_count;
        w_ovf      = 1'b0;
        w_unf      = 1'b0;
        w_load_err = 1'b0;
        if (clr) begin
            w_next = '0;
        end else if (load) begin
            if (&w_digit_ok) begin
                w_next = load_bcd;
            end else begin
                w_load_err = 1'b1;
            end
        end else if (inc && !dec) begin
            w_ovf = w_carry[DIGITS];
            // The ripple result already wraps 9..9 to 0..0; saturation just holds.
            if (!(w_carry[DIGITS] && c_SAT)) begin
                w_next = w_inc_val;
            end
        end else if (dec && !inc) begin
            w_unf = w_borrow[DIGITS];
            if (!(w_borrow[DIGITS] && c_SAT)) begin
                w_next = w_dec_val;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count    <= '0;
            r_ovf      <= 1'b0;
            r_unf      <= 1'b0;
            r_load_err <= 1'b0;
        end else begin
            r_count    <= w_next;
            r_ovf      <= w_ovf;
            r_unf      <= w_unf;
            r_load_err <= w_load_err;
        end
    end

    assign count_bcd = r_count;
    assign ovf       = r_ovf;
    assign unf       = r_unf;
    assign load_err  = r_load_err;
    assign is_zero   = w_borrow[DIGITS];
    assign is_max    = w_carry[DIGITS];

endmodule

`default_nettype wire

// File: tb/tb_bcd_odo_counter_n.sv
// ============================================================================
//  Module      : tb_bcd_odo_counter_n
//  Description : Scoreboard bench driving four odometer variants in lockstep
//                against an integer reference model.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_bcd_odo_counter_n;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        clr   = 1'b0;
    logic        load  = 1'b0;
    logic        inc   = 1'b0;
    logic        dec   = 1'b0;
    logic [31:0] lb    = '0;

    always #5 clk = ~clk;

    logic [11:0] c0;
    logic [11:0] c1;
    logic [15:0] c2;
    logic [3:0]  c3;
    logic [3:0]  ovf_v, unf_v, le_v, z_v, mx_v;
    logic [3:0][31:0] act;

    assign act[0] = {20'd0, c0};
    assign act[1] = {20'd0, c1};
    assign act[2] = {16'd0, c2};
    assign act[3] = {28'd0, c3};

    bcd_odo_counter_n #(.DIGITS(3), .SATURATE(0)) u_d3w (
        .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .load_bcd(lb[11:0]),
        .inc(inc), .dec(dec), .count_bcd(c0), .ovf(ovf_v[0]), .unf(unf_v[0]),
        .load_err(le_v[0]), .is_zero(z_v[0]), .is_max(mx_v[0]));

    bcd_odo_counter_n #(.DIGITS(3), .SATURATE(1)) u_d3s (
        .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .load_bcd(lb[11:0]),
        .inc(inc), .dec(dec), .count_bcd(c1), .ovf(ovf_v[1]), .unf(unf_v[1]),
        .load_err(le_v[1]), .is_zero(z_v[1]), .is_max(mx_v[1]));

    bcd_odo_counter_n #(.DIGITS(4), .SATURATE(0)) u_d4w (
        .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .load_bcd(lb[15:0]),
        .inc(inc), .dec(dec), .count_bcd(c2), .ovf(ovf_v[2]), .unf(unf_v[2]),
        .load_err(le_v[2]), .is_zero(z_v[2]), .is_max(mx_v[2]));

    bcd_odo_counter_n #(.DIGITS(1), .SATURATE(0)) u_d1w (
        .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .load_bcd(lb[3:0]),
        .inc(inc), .dec(dec), .count_bcd(c3), .ovf(ovf_v[3]), .unf(unf_v[3]),
        .load_err(le_v[3]), .is_zero(z_v[3]), .is_max(mx_v[3]));

    typedef struct packed {
        logic [3:0][31:0] cnt;
        logic [3:0]       ovf;
        logic [3:0]       unf;
        logic [3:0]       le;
        logic [3:0]       z;
        logic [3:0]       mx;
    } exp_t;

    exp_t q[$];
    int   tests  = 0;
    int   failed = 0;
    int   mv[4]  = '{0, 0, 0, 0};
    int   dg[4]  = '{3, 3, 4, 1};
    int   sa[4]  = '{0, 1, 0, 0};

    function automatic int pow10(input int d);
        int p;
        p = 1;
        for (int j = 0; j < d; j++) p = p * 10;
        return p;
    endfunction

    function automatic logic [31:0] to_bcd(input int d, input int v);
        logic [31:0] r;
        int          t;
        r = '0;
        t = v;
        for (int j = 0; j < d; j++) begin
            r[4*j +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    // Reference: the count is an integer in 0..10^D-1; BCD only appears on output.
    task automatic step(input logic c, input logic l, input logic [31:0] b,
                        input logic i, input logic dn);
        exp_t e;
        @(negedge clk);
        clr = c; load = l; lb = b; inc = i; dec = dn;
        e = '0;
        for (int k = 0; k < 4; k++) begin
            int lim;
            int v;
            int val;
            int nib;
            bit ok;
            lim = pow10(dg[k]) - 1;
            v   = mv[k];
            val = 0;
            ok  = 1'b1;
            for (int j = dg[k] - 1; j >= 0; j--) begin
                nib = int'(b[4*j +: 4]);
                if (nib > 9) ok = 1'b0;
                val = val * 10 + nib;
            end
            if (c) begin
                v = 0;
            end else if (l) begin
                if (ok) v = val;
                else    e.le[k] = 1'b1;
            end else if (i && !dn) begin
                if (mv[k] == lim) begin
                    e.ovf[k] = 1'b1;
                    v = (sa[k] != 0) ? lim : 0;
                end else begin
                    v = mv[k] + 1;
                end
            end else if (dn && !i) begin
                if (mv[k] == 0) begin
                    e.unf[k] = 1'b1;
                    v = (sa[k] != 0) ? 0 : lim;
                end else begin
                    v = mv[k] - 1;
                end
            end
            mv[k]    = v;
            e.cnt[k] = to_bcd(dg[k], v);
            e.z[k]   = (v == 0);
            e.mx[k]  = (v == lim);
        end
        q.push_back(e);
    endtask

    task automatic chk_reset(input string nm);
        for (int k = 0; k < 4; k++) begin
            tests++;
            if (act[k] !== 32'd0 || ovf_v[k] !== 1'b0 || unf_v[k] !== 1'b0 ||
                le_v[k] !== 1'b0 || z_v[k] !== 1'b1 || mx_v[k] !== 1'b0) begin
                failed++;
                $display("FAIL %s inst%0d: got cnt=%h ovf=%b unf=%b lerr=%b zero=%b max=%b, need cnt=0 pulses=0 zero=1 max=0",
                         nm, k, act[k], ovf_v[k], unf_v[k], le_v[k], z_v[k], mx_v[k]);
            end
        end
    endtask

    // Monitor: every post-edge sample is a DUT output to check.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n && q.size() > 0) begin
                e = q.pop_front();
                for (int k = 0; k < 4; k++) begin
                    tests++;
                    if (act[k] !== e.cnt[k] || ovf_v[k] !== e.ovf[k] || unf_v[k] !== e.unf[k] ||
                        le_v[k] !== e.le[k] || z_v[k] !== e.z[k] || mx_v[k] !== e.mx[k]) begin
                        failed++;
                        $display("FAIL cycle inst%0d @%0t: got cnt=%h ovf=%b unf=%b lerr=%b zero=%b max=%b, need cnt=%h ovf=%b unf=%b lerr=%b zero=%b max=%b",
                                 k, $time, act[k], ovf_v[k], unf_v[k], le_v[k], z_v[k], mx_v[k],
                                 e.cnt[k], e.ovf[k], e.unf[k], e.le[k], e.z[k], e.mx[k]);
                    end
                end
            end
        end
    end

    initial begin
        logic [31:0] b;
        logic        rc, rl, ri, rd;
        int          r;
        bit          up;

        #12;
        chk_reset("reset");
        @(negedge clk);
        rst_n = 1'b1;

        repeat (999) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);

        step(1'b0, 1'b1, 32'h001, 1'b0, 1'b0);
        repeat (3) step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);

        step(1'b0, 1'b1, 32'h1090, 1'b0, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);

        step(1'b0, 1'b1, 32'h1A5, 1'b0, 1'b0);
        step(1'b1, 1'b1, 32'h123, 1'b1, 1'b0);

        repeat (7) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        clr = 1'b0; load = 1'b0; inc = 1'b0; dec = 1'b0;
        #1;
        chk_reset("async_reset");
        for (int k = 0; k < 4; k++) mv[k] = 0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);

        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        repeat (10) step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);

        up = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            if (n % 500 == 0) up = ~up;
            r  = int'($urandom_range(0, 63));
            rc = (r == 0);
            rl = (r >= 1 && r <= 4);
            for (int j = 0; j < 8; j++)
                b[4*j +: 4] = ($urandom_range(0, 19) < 18) ? 4'($urandom_range(0, 9))
                                                           : 4'($urandom_range(10, 15));
            ri = up ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            rd = up ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            step(rc, rl, b, ri, rd);
        end
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);

        @(posedge clk);
        #2;
        tests++;
        if (q.size() != 0) begin
            failed++;
            $display("FAIL drain: got %0d unchecked entries, need 0", q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

`default_nettype wire
